lcd_frame_feeder: RTL and testbench
===================================

// Module: lcd_frame_feeder
// PURPOSE
// - Pixel source directly upstream of the LCD timing driver. It answers the driver's
//   lcd_request/lcd_xpos/lcd_ypos with lcd_data exactly one clk later.
// - Pixels come from a show-ahead frame FIFO, normally the SDRAM read side.
//   Each FIFO word is {sof, rgb[23:0]}; sof=1 marks pixel (0,0) of a frame.
// - Locks the FIFO stream to the display raster.
// - Recovers from underflow and misalignment without stopping the display.
// PARAMETERS
// - DATA_W           24        RGB width
// - CNT_W            16        width of the error counters
// - IDLE_COLOR       24'h000000  output while unlocked or when no request is pending
// - UNDERFLOW_COLOR  24'h0000FF  output for a requested pixel when the FIFO is empty
// PORTS
// - clk            in   1         pixel clock; same clock as the LCD driver
// - rst_n          in   1         asynchronous, active-low reset
// - lcd_request    in   1         driver asks for a pixel at (lcd_xpos, lcd_ypos)
// - lcd_xpos       in   11        requested column
// - lcd_ypos       in   11        requested row
// - lcd_data       out  DATA_W    pixel to the driver; registered
// - fifo_rdata     in   DATA_W+1  FIFO head word {sof, rgb}; valid while !fifo_empty
// - fifo_empty     in   1         FIFO empty
// - fifo_rdreq     out  1         pop the head word; combinational, same cycle as decision
// - frame_locked   out  1         1 while state == STREAM
// - underflow_cnt  out  CNT_W     requested pixels served while the FIFO was empty; saturating
// - resync_cnt     out  CNT_W     misalignment events; saturating
// - clear_cnt      in   1         synchronous clear of both counters
// BEHAVIOUR
// - Reset values
//   - state = SEEK; lcd_data = 0; both counters = 0; frame_locked = 0.
//   - fifo_rdreq is forced to 0 while rst_n is low.
// - Latency: a decision is made in the cycle where lcd_request=1; lcd_data carries the
//   result on the next clk edge. Cycles with lcd_request=0 load lcd_data <= IDLE_COLOR.
// - Definitions: origin = (lcd_xpos==0 && lcd_ypos==0); head_sof = !fifo_empty && fifo_rdata[DATA_W].
// - SEEK (flush to the frame start)
//   - Pop while !fifo_empty && !head_sof, regardless of lcd_request.
//   - Move to WAIT_SOF when head_sof. The sof word is not popped.
//   - Requested pixels output IDLE_COLOR.
// - WAIT_SOF (sof word held at the FIFO head)
//   - No pops except as below.
//   - lcd_request && origin: pop; lcd_data <= rgb; go to STREAM.
//   - Other requests: output IDLE_COLOR.
// - STREAM, on lcd_request; the first matching rule wins
//   1. origin && head_sof: pop and output rgb (normal frame start).
//   2. origin && !fifo_empty && !head_sof: no pop; IDLE_COLOR; resync_cnt++; go to SEEK.
//   3. !origin && head_sof: next frame arrived early. No pop; IDLE_COLOR; resync_cnt++;
//      go to WAIT_SOF.
//   4. fifo_empty: no pop; UNDERFLOW_COLOR; underflow_cnt++; stay in STREAM.
//      The missing pixel is skipped, not delayed.
//   5. Otherwise: pop and output rgb.
// - STREAM without lcd_request: no pop, no state change.
// - fifo_rdreq is never asserted while fifo_empty=1.
// - Counters saturate at all ones. clear_cnt has priority over a same-cycle increment.
// - Asynchronous reset mid-frame returns the block to SEEK. Relock happens at the next
//   sof plus origin request.
// TESTING
// - Reset, 2 blank words, then sof frame 4x2 (0x000001..0x000008), requests in raster order
//   -> 2 words flushed in SEEK; lcd_data 0x000001..0x000008 one clk after each request;
//   frame_locked=1.
// - Back-to-back frames, FIFO never empty, 100 frames -> zero idle pixels;
//   both counters remain 0.
// - FIFO held empty for 3 requested pixels mid-line -> 3 UNDERFLOW_COLOR pixels;
//   underflow_cnt=3; later pixels continue from the FIFO head.
// - sof word reaches the head at pixel (2,1) of a 4x2 frame -> IDLE_COLOR; resync_cnt=1;
//   WAIT_SOF; relock at the next origin request.
// - Non-sof word at the head on an origin request -> resync_cnt=1; SEEK flushes up to
//   the next sof; relock follows.
// - underflow_cnt preset near 16'hFFFF, then more underflows, then clear_cnt pulsed
//   with an underflow in the same cycle -> value holds at 16'hFFFF, then clears to 0
//   (clear wins over the increment).

Source files
------------

// File: rtl/lcd_frame_feeder.sv
// Pixel source for the LCD timing driver: locks a show-ahead {sof, rgb} FIFO stream to
// the display raster and recovers from underflow and misalignment without stalling.
module lcd_frame_feeder #(
  parameter int                DATA_W          = 24,
  parameter int                CNT_W           = 16,
  parameter logic [DATA_W-1:0] IDLE_COLOR      = 'h000000,
  parameter logic [DATA_W-1:0] UNDERFLOW_COLOR = 'h0000FF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lcd_request,
  input  logic [10:0]       lcd_xpos,
  input  logic [10:0]       lcd_ypos,
  output logic [DATA_W-1:0] lcd_data,
  input  logic [DATA_W:0]   fifo_rdata,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  output logic              frame_locked,
  output logic [CNT_W-1:0]  underflow_cnt,
  output logic [CNT_W-1:0]  resync_cnt,
  input  logic              clear_cnt
);

  typedef enum logic [1:0] {
    ST_SEEK,
    ST_WAIT_SOF,
    ST_STREAM
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_lcd_data;
  logic [DATA_W-1:0]   w_data_next;
  logic [CNT_W-1:0]    r_underflow_cnt;
  logic [CNT_W-1:0]    r_resync_cnt;
  logic                w_pop;
  logic                w_underflow_inc;
  logic                w_resync_inc;

  logic                w_origin;
  logic                w_head_sof;
  logic [DATA_W-1:0]   w_rgb;

  assign w_origin   = (lcd_xpos == 11'd0) && (lcd_ypos == 11'd0);
  assign w_head_sof = !fifo_empty && fifo_rdata[DATA_W];
  assign w_rgb      = fifo_rdata[DATA_W-1:0];

  // NOTE: every output of this block gets a default first so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state    = r_state;
    w_pop           = 1'b0;
    w_data_next     = IDLE_COLOR;
    w_underflow_inc = 1'b0;
    w_resync_inc    = 1'b0;

    unique case (r_state)
      ST_SEEK: begin
        // Flush everything ahead of the next frame start; the sof word stays at the head.
        if (w_head_sof) begin
          w_next_state = ST_WAIT_SOF;
        end else if (!fifo_empty) begin
          w_pop = 1'b1;
        end
      end

      ST_WAIT_SOF: begin
        if (lcd_request && w_origin && w_head_sof) begin
          w_pop        = 1'b1;
          w_data_next  = w_rgb;
          w_next_state = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (lcd_request) begin
          if (w_origin && w_head_sof) begin
            w_pop       = 1'b1;
            w_data_next = w_rgb;
          end else if (w_origin && !fifo_empty) begin
            w_resync_inc = 1'b1;
            w_next_state = ST_SEEK;
          end else if (w_head_sof) begin
            // Next frame arrived before the raster finished this one.
            w_resync_inc = 1'b1;
            w_next_state = ST_WAIT_SOF;
          end else if (fifo_empty) begin
            w_data_next     = UNDERFLOW_COLOR;
            w_underflow_inc = 1'b1;
          end else begin
            w_pop       = 1'b1;
            w_data_next = w_rgb;
          end
        end
      end

      default: w_next_state = ST_SEEK;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; the reset branch is asynchronous on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SEEK;
      r_lcd_data <= '0;
    end else begin
      r_state    <= w_next_state;
      r_lcd_data <= w_data_next;
    end
  end

  // Saturating error counters; a clear in the same cycle beats the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow_cnt <= '0;
      r_resync_cnt    <= '0;
    end else if (clear_cnt) begin
      r_underflow_cnt <= '0;
      r_resync_cnt    <= '0;
    end else begin
      if (w_underflow_inc && (r_underflow_cnt != '1)) r_underflow_cnt <= r_underflow_cnt + 1'b1;
      if (w_resync_inc && (r_resync_cnt != '1))       r_resync_cnt    <= r_resync_cnt + 1'b1;
    end
  end

  assign fifo_rdreq    = rst_n && w_pop && !fifo_empty;
  assign lcd_data      = r_lcd_data;
  assign frame_locked  = (r_state == ST_STREAM);
  assign underflow_cnt = r_underflow_cnt;
  assign resync_cnt    = r_resync_cnt;

endmodule

// File: tb/tb_lcd_frame_feeder.sv
// Directed bench for lcd_frame_feeder: a queue models the show-ahead FIFO, inputs change
// on the falling edge and outputs are compared there.
module tb_lcd_frame_feeder;

  localparam logic [23:0] IDLE = 24'h000000;
  localparam logic [23:0] UFC  = 24'h0000FF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lcd_request;
  logic [10:0] lcd_xpos;
  logic [10:0] lcd_ypos;
  logic [23:0] lcd_data;
  logic [24:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic        frame_locked;
  logic [15:0] underflow_cnt;
  logic [15:0] resync_cnt;
  logic        clear_cnt;

  logic [24:0] q[$];
  int          n_popped  = 0;
  int          n_applied = 0;
  bit          hold_empty = 1'b0;
  int          total = 0;
  int          bad   = 0;
  int          n0;

  bit          pend_chk = 1'b0;
  logic [23:0] pend_exp;
  string       pend_tag;

  always #5 clk = ~clk;

  lcd_frame_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lcd_request  (lcd_request),
    .lcd_xpos     (lcd_xpos),
    .lcd_ypos     (lcd_ypos),
    .lcd_data     (lcd_data),
    .fifo_rdata   (fifo_rdata),
    .fifo_empty   (fifo_empty),
    .fifo_rdreq   (fifo_rdreq),
    .frame_locked (frame_locked),
    .underflow_cnt(underflow_cnt),
    .resync_cnt   (resync_cnt),
    .clear_cnt    (clear_cnt)
  );

  always @(posedge clk) if (fifo_rdreq) n_popped++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sync_fifo();
    while (n_applied != n_popped) begin
      if (q.size() > 0) void'(q.pop_front());
      n_applied++;
    end
    fifo_rdata = (q.size() > 0) ? q[0] : 25'd0;
    fifo_empty = hold_empty || (q.size() == 0);
  endtask

  task automatic push(input bit sof, input logic [23:0] rgb);
    q.push_back({sof, rgb});
    sync_fifo();
  endtask

  task automatic push_frame(input logic [23:0] base, input int n);
    for (int i = 0; i < n; i++) push(i == 0, base + 24'(i));
  endtask

  // One clock: compare the result of the previous request, then drive the next one.
  task automatic step(input bit req, input int x, input int y, input bit chk,
                      input logic [23:0] exp, input string tag);
    @(negedge clk);
    sync_fifo();
    if (pend_chk) check(pend_tag, {8'd0, lcd_data}, {8'd0, pend_exp});
    lcd_request = req;
    lcd_xpos    = 11'(x);
    lcd_ypos    = 11'(y);
    pend_chk    = chk;
    pend_exp    = exp;
    pend_tag    = tag;
  endtask

  task automatic px(input int x, input int y, input logic [23:0] exp, input string tag);
    step(1'b1, x, y, 1'b1, exp, tag);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, IDLE, "");
  endtask

  task automatic frame_req(input logic [23:0] base, input string tag);
    for (int i = 0; i < 8; i++) px(i % 4, i / 4, base + 24'(i), tag);
  endtask

  initial begin
    rst_n       = 1'b0;
    lcd_request = 1'b0;
    lcd_xpos    = '0;
    lcd_ypos    = '0;
    clear_cnt   = 1'b0;
    fifo_empty  = 1'b1;
    fifo_rdata  = '0;

    // Reset: a blank word is at the head, yet nothing may be popped.
    push(1'b0, 24'hAAAAAA);
    repeat (3) @(negedge clk);
    #1;
    check("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    check("rst_data", {8'd0, lcd_data}, 32'd0);
    check("rst_locked", {31'd0, frame_locked}, 32'd0);
    check("rst_ucnt", {16'd0, underflow_cnt}, 32'd0);
    check("rst_rcnt", {16'd0, resync_cnt}, 32'd0);

    // Two blank words then a 4x2 frame 1..8.
    push(1'b0, 24'hBBBBBB);
    push_frame(24'h000001, 8);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) idle();
    check("seek_flush", n_popped, 32'd2);
    check("seek_unlocked", {31'd0, frame_locked}, 32'd0);
    frame_req(24'h000001, "frame1_px");
    idle();
    check("frame1_locked", {31'd0, frame_locked}, 32'd1);

    // 100 back-to-back frames, two frames kept queued ahead of the raster.
    push_frame(24'h100000, 8);
    push_frame(24'h100100, 8);
    for (int f = 0; f < 100; f++) begin
      frame_req(24'h100000 + 24'(f * 256), "b2b_px");
      if (f + 2 < 100) push_frame(24'h100000 + 24'((f + 2) * 256), 8);
    end
    idle();
    check("b2b_ucnt", {16'd0, underflow_cnt}, 32'd0);
    check("b2b_rcnt", {16'd0, resync_cnt}, 32'd0);
    check("b2b_locked", {31'd0, frame_locked}, 32'd1);

    // FIFO empty for three mid-line pixels; the stream resumes from the head.
    push_frame(24'h300001, 8);
    px(0, 0, 24'h300001, "uf_px0");
    px(1, 0, 24'h300002, "uf_px1");
    hold_empty = 1'b1;
    px(2, 0, UFC, "uf_gap0");
    #1;
    check("uf_no_rdreq", {31'd0, fifo_rdreq}, 32'd0);
    px(3, 0, UFC, "uf_gap1");
    px(0, 1, UFC, "uf_gap2");
    hold_empty = 1'b0;
    px(1, 1, 24'h300003, "uf_resume0");
    px(2, 1, 24'h300004, "uf_resume1");
    px(3, 1, 24'h300005, "uf_resume2");
    idle();
    check("uf_cnt", {16'd0, underflow_cnt}, 32'd3);
    check("uf_locked", {31'd0, frame_locked}, 32'd1);

    // Reset mid-frame with 3 stale words queued; relock must flush them first.
    push_frame(24'h400001, 6);
    push_frame(24'h500001, 8);
    rst_n = 1'b0;
    #1;
    check("midrst_locked", {31'd0, frame_locked}, 32'd0);
    check("midrst_ucnt", {16'd0, underflow_cnt}, 32'd0);
    idle();
    n0 = n_popped;
    rst_n = 1'b1;
    repeat (5) idle();
    check("midrst_flush", n_popped - n0, 32'd3);

    // Short frame B: the sof of C reaches the head at pixel (2,1).
    px(0, 0, 24'h400001, "early_b0");
    px(1, 0, 24'h400002, "early_b1");
    px(2, 0, 24'h400003, "early_b2");
    px(3, 0, 24'h400004, "early_b3");
    px(0, 1, 24'h400005, "early_b4");
    px(1, 1, 24'h400006, "early_b5");
    px(2, 1, IDLE, "early_sof");
    px(3, 1, IDLE, "early_wait");
    idle();
    check("early_rcnt", {16'd0, resync_cnt}, 32'd1);
    check("early_unlocked", {31'd0, frame_locked}, 32'd0);
    frame_req(24'h500001, "early_relock_px");
    idle();
    check("early_relocked", {31'd0, frame_locked}, 32'd1);

    // Non-sof words at the head on an origin request.
    clear_cnt = 1'b1;
    idle();
    clear_cnt = 1'b0;
    idle();
    check("clr_rcnt", {16'd0, resync_cnt}, 32'd0);
    push(1'b0, 24'h600001);
    push(1'b0, 24'h600002);
    push_frame(24'h700001, 8);
    n0 = n_popped;
    px(0, 0, IDLE, "mis_origin");
    repeat (3) idle();
    check("mis_rcnt", {16'd0, resync_cnt}, 32'd1);
    check("mis_flush", n_popped - n0, 32'd2);
    check("mis_unlocked", {31'd0, frame_locked}, 32'd0);
    frame_req(24'h700001, "mis_relock_px");
    idle();
    check("mis_relocked", {31'd0, frame_locked}, 32'd1);

    // Underflow counter saturation, then clear beating a same-cycle increment.
    clear_cnt = 1'b1;
    idle();
    clear_cnt = 1'b0;
    for (int i = 0; i < 65533; i++) step(1'b1, 1, 0, 1'b0, IDLE, "");
    idle();
    check("sat_near", {16'd0, underflow_cnt}, 32'h0000FFFD);
    px(1, 0, UFC, "sat_px0");
    px(1, 0, UFC, "sat_px1");
    px(1, 0, UFC, "sat_px2");
    idle();
    check("sat_hold", {16'd0, underflow_cnt}, 32'h0000FFFF);
    px(1, 0, UFC, "sat_clr_px");
    clear_cnt = 1'b1;
    idle();
    clear_cnt = 1'b0;
    check("sat_clear", {16'd0, underflow_cnt}, 32'd0);
    check("sat_rcnt", {16'd0, resync_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
